// File: rtl/battery_pack_model_if.sv
// Signal bundle of the two-cell battery pack model: run/load/charger controls in,
// cell levels, load-selection flags and the update pulse out.
interface battery_pack_model_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load_on;
    logic             charge_en;
    logic [WIDTH-1:0] battA;
    logic [WIDTH-1:0] battB;
    logic             sel_a;
    logic             sel_b;
    logic             all_empty;
    logic             step;

    // The controller drives the controls; the pack model answers with levels and flags.
    modport master (
        output en, load_on, charge_en,
        input  battA, battB, sel_a, sel_b, all_empty, step
    );

    modport slave (
        input  en, load_on, charge_en,
        output battA, battB, sel_a, sel_b, all_empty, step
    );
endinterface

// File: rtl/battery_pack_model.sv
// Two-cell battery pack source model: discharges the loaded cell, charges the idle one
// on a prescaled tick, and hands the load over when the active cell empties.
module battery_pack_model #(
    parameter int WIDTH      = 4,
    parameter int TICK_DIV   = 8,
    parameter int RESUME_LVL = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    battery_pack_model_if.slave  bus,
    output logic [1:0]           dbgState
);
    localparam int               CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]    LAST   = CW'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] FULL   = '1;
    localparam logic [WIDTH-1:0] EMPTY  = '0;
    localparam logic [WIDTH-1:0] RESUME = WIDTH'(RESUME_LVL);

    typedef enum logic [1:0] {
        USE_A    = 2'd0,
        USE_B    = 2'd1,
        DEPLETED = 2'd2
    } stateT;

    stateT            state, nextState;
    logic [CW-1:0]    cnt, nextCnt;
    logic [WIDTH-1:0] levelA, levelB, nextA, nextB;
    logic             stepQ, tick;

    function automatic logic [WIDTH-1:0] decSat(input logic [WIDTH-1:0] v);
        return (v == EMPTY) ? EMPTY : v - WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] incSat(input logic [WIDTH-1:0] v);
        return (v == FULL) ? FULL : v + WIDTH'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= USE_A;
            cnt    <= '0;
            levelA <= FULL;
            levelB <= FULL;
            stepQ  <= 1'b0;
        end else begin
            state  <= nextState;
            cnt    <= nextCnt;
            levelA <= nextA;
            levelB <= nextB;
            stepQ  <= tick;
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        nextA     = levelA;
        nextB     = levelB;
        tick      = 1'b0;

        if (bus.en) begin
            if (cnt == LAST) begin
                tick    = 1'b1;
                nextCnt = '0;
            end else begin
                nextCnt = cnt + CW'(1);
            end
        end

        if (tick) begin
            // Level arithmetic first; transitions below look at the updated levels.
            case (state)
                USE_A: begin
                    if (bus.load_on)        nextA = decSat(levelA);
                    else if (bus.charge_en) nextA = incSat(levelA);
                    if (bus.charge_en)      nextB = incSat(levelB);
                end
                USE_B: begin
                    if (bus.load_on)        nextB = decSat(levelB);
                    else if (bus.charge_en) nextB = incSat(levelB);
                    if (bus.charge_en)      nextA = incSat(levelA);
                end
                default: begin
                    if (bus.charge_en) begin
                        nextA = incSat(levelA);
                        nextB = incSat(levelB);
                    end
                end
            endcase

            case (state)
                USE_A: begin
                    if (nextA == EMPTY)
                        nextState = (nextB == EMPTY) ? DEPLETED : USE_B;
                end
                USE_B: begin
                    if (nextB == EMPTY)
                        nextState = (nextA == EMPTY) ? DEPLETED : USE_A;
                end
                default: begin
                    if (nextA >= RESUME)      nextState = USE_A;
                    else if (nextB >= RESUME) nextState = USE_B;
                    else                      nextState = DEPLETED;
                end
            endcase
        end
    end

    assign bus.battA     = levelA;
    assign bus.battB     = levelB;
    assign bus.sel_a     = (state == USE_A);
    assign bus.sel_b     = (state == USE_B);
    assign bus.all_empty = (state == DEPLETED);
    assign bus.step      = stepQ;
    assign dbgState      = state;
endmodule

// File: tb/tb_battery_pack_model.sv
// Directed bench for battery_pack_model: stimulus pushes the hand-computed state after
// each tick into exp_q; a monitor pops and compares on every step pulse.
module tb_battery_pack_model;
    logic       clk;
    logic       rst;
    logic [1:0] dbgState;

    battery_pack_model_if #(.WIDTH(4)) bus ();

    battery_pack_model #(.WIDTH(4), .TICK_DIV(8), .RESUME_LVL(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .dbgState (dbgState)
    );

    int errors = 0;
    int checks = 0;
    int tickNum = 0;
    logic [10:0] exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int a, input int b, input bit sa, input bit sb, input bit ae);
        exp_q.push_back({4'(a), 4'(b), sa, sb, ae});
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drainTimeout: %0d ticks still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Cycles from now until step is seen, bounded; also reports whether levels held meanwhile.
    task automatic waitStep(input int budget, input logic [7:0] hold, output int lat,
                            output bit held);
        lat  = 0;
        held = 1'b1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            #1;
            if (bus.step) begin
                lat = i;
                break;
            end
            if ({bus.battA, bus.battB} != hold) held = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.step) begin
            tickNum++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpectedStep: tick %0d with nothing expected", tickNum);
            end else begin
                logic [10:0] e;
                e = exp_q.pop_front();
                check($sformatf("tick%0d", tickNum),
                      16'({bus.battA, bus.battB, bus.sel_a, bus.sel_b, bus.all_empty}), 16'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit held;
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.load_on   = 1'b0;
        bus.charge_en = 1'b0;
        repeat (2) @(negedge clk);
        check("resetState", 16'({bus.battA, bus.battB, bus.sel_a, bus.sel_b, bus.all_empty,
              bus.step}), 16'({4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0}));

        // Discharge A to empty, hand over to B, discharge B to DEPLETED.
        rst         = 1'b0;
        bus.en      = 1'b1;
        bus.load_on = 1'b1;
        for (int k = 1; k <= 15; k++) push(15 - k, 15, k < 15, k == 15, 0);
        for (int k = 1; k <= 15; k++) push(0, 15 - k, 0, k < 15, k == 15);
        push(0, 0, 0, 0, 1);
        push(0, 0, 0, 0, 1);
        waitStep(20, 8'hFF, lat, held);
        check("firstTickLatency", 16'(lat), 16'd8);
        check("heldBeforeTick", 16'(held), 16'd1);
        waitDrain(40 * 8);

        // Recharge from DEPLETED: A wins the resume, then both saturate at full.
        bus.load_on   = 1'b0;
        bus.charge_en = 1'b1;
        for (int k = 1; k <= 3; k++) push(k, k, 0, 0, 1);
        for (int k = 4; k <= 15; k++) push(k, k, 1, 0, 0);
        push(15, 15, 1, 0, 0);
        push(15, 15, 1, 0, 0);
        waitDrain(20 * 8);

        // Drain A again into USE_B, bring B to 12.
        bus.load_on   = 1'b1;
        bus.charge_en = 1'b0;
        for (int k = 1; k <= 15; k++) push(15 - k, 15, k < 15, k == 15, 0);
        for (int k = 1; k <= 3; k++) push(0, 15 - k, 0, 1, 0);
        waitDrain(20 * 8);

        // Load and charger together: loaded B falls while idle A rises.
        bus.charge_en = 1'b1;
        for (int k = 1; k <= 4; k++) push(k, 12 - k, 0, 1, 0);
        waitDrain(6 * 8);

        // Freeze mid-count: count stands at 3, so the tick comes 5 cycles after resuming.
        repeat (3) @(negedge clk);
        bus.en = 1'b0;
        push(5, 7, 0, 1, 0);
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (bus.step) held = 1'b0;
        end
        check("noStepWhileFrozen", 16'(held), 16'd1);
        check("levelsFrozen", 16'({bus.battA, bus.battB}), 16'({4'd4, 4'd8}));
        bus.en = 1'b1;
        waitStep(20, 8'h48, lat, held);
        check("resumeLatency", 16'(lat), 16'd5);
        waitDrain(4 * 8);

        // Asynchronous reset between edges mid-discharge.
        bus.charge_en = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("asyncReset", 16'({bus.battA, bus.battB, bus.sel_a, bus.sel_b, bus.all_empty,
              bus.step}), 16'({4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        push(14, 15, 1, 0, 0);
        waitStep(20, 8'hFF, lat, held);
        check("postResetLatency", 16'(lat), 16'd8);
        waitDrain(2 * 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
